// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result bus of the nibble-serial adder.
// The overflow signal exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef NSA_OVERFLOW_EN
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
`else
    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );
    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_four_bit_adder.sv
// Structural 4-bit ripple-carry adder built from gate-level full adders.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one shared 4-bit adder, WIDTH/4 BUSY cycles per operation.
// Define NSA_OVERFLOW_EN to add the signed-overflow output.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_co;
`ifdef NSA_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    // Operands shift right every BUSY cycle, so the current nibble is always bits [3:0].
    four_bit_adder u_add (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_co)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch behind.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef NSA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.carry_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
                carry_d = nib_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    state_d = DONE;
`ifdef NSA_OVERFLOW_EN
                    // Same-sign operands producing an opposite-sign MSB nibble.
                    ovf_d = (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                            (nib_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
`ifdef NSA_OVERFLOW_EN
    assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus
// randomized operations against an arithmetic reference (NSA_OVERFLOW_EN aware).
module tb_nibble_serial_adder;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain (WIDTH+1)-bit addition; overflow from operand/result signs.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, b, input logic cin);
        logic [WIDTH:0] r;
        r = ref_add(a, b, cin);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] a, b, input logic cin);
        logic [WIDTH:0] exp;
        int cyc;
        exp = ref_add(a, b, cin);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, NIBBLES);
        check({tag, "_sum"}, bus.sum, exp[WIDTH-1:0]);
        check({tag, "_cout"}, bus.carry_out, exp[WIDTH]);
`ifdef NSA_OVERFLOW_EN
        check({tag, "_ovf"}, bus.overflow, ref_ovf(a, b, cin));
`endif
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, b,
                          input logic cin, input int hold);
        logic [WIDTH:0] exp;
        int cyc;
        exp = ref_add(a, b, cin);
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.carry_in  = cin;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.carry_in = 1'($urandom);
        check({tag, "_busy_ready"}, bus.in_ready, 1'b0);
        wait_result(tag, a, b, cin);
        // Hold the result and poke in_valid; nothing may move.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = WIDTH'($urandom);
            tick();
            check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            check({tag, "_hold_sum"}, bus.sum, exp[WIDTH-1:0]);
            check({tag, "_hold_cout"}, bus.carry_out, exp[WIDTH]);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle_ready"}, bus.in_ready, 1'b1);
        check({tag, "_idle_valid"}, bus.out_valid, 1'b0);
        check({tag, "_idle_sum"}, bus.sum, exp[WIDTH-1:0]);
    endtask

    initial begin
        int seen;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, '0);
        check("rst_cout", bus.carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("d1234", 16'h1234, 16'h4321, 1'b1, 3);
        run_op("dffff_1", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("dffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1);
        run_op("d7fff_1", 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op("d8000_8000", 16'h8000, 16'h8000, 1'b0, 0);

        // Reset in the second BUSY cycle throws the operation away.
        bus.in_valid = 1'b1;
        bus.a        = 16'h00FF;
        bus.b        = 16'h0001;
        bus.carry_in = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b1);
        check("mid_rst_sum", bus.sum, '0);
        check("mid_rst_cout", bus.carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("post_rst_no_valid", seen, 0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 0);

        // Back-to-back with in_valid held high and out_ready high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hA5A5;
        bus.b         = 16'h1111;
        bus.carry_in  = 1'b1;
        tick();
        bus.a        = 16'h0F0F;
        bus.b        = 16'hF0F1;
        bus.carry_in = 1'b0;
        wait_result("b2b_1", 16'hA5A5, 16'h1111, 1'b1);
        tick();
        check("b2b_idle", bus.in_ready, 1'b1);
        tick();
        check("b2b_accept", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        wait_result("b2b_2", 16'h0F0F, 16'hF0F1, 1'b0);
        tick();
        bus.out_ready = 1'b0;

        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            run_op("rand", ra, rb, rc, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
